// File: rtl/axil_regbank_v2.sv
// AXI4-Lite slave register bank with byte strobes, read-only status slots and per-register write pulses.
// Optional macro AXIL_REGBANK_ERR_RESP_EN: illegal accesses answer SLVERR instead of OKAY.
module axil_regbank_v2 #(
  parameter int                              C_S_AXI_DATA_WIDTH = 32,
  parameter int                              C_S_AXI_ADDR_WIDTH = 5,
  parameter int                              NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0]             RO_MASK            = '0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0]   RESET_VAL          = '0
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int BYTES    = DW / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W    = AW - ADDR_LSB;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGBANK_ERR_RESP_EN
  localparam logic [1:0] ERR_RESP  = 2'b10;
`else
  localparam logic [1:0] ERR_RESP  = 2'b00;
`endif

  localparam logic [0:0] AW_IDLE = 1'b0;
  localparam logic [0:0] AW_HELD = 1'b1;
  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_HELD  = 1'b1;

  logic             readyEn_q;
  logic [0:0]       awState_q, awState_d;
  logic [0:0]       wState_q, wState_d;
  logic [IDX_W-1:0] awIdx_q, awIdx_d;
  logic [DW-1:0]    wData_q, wData_d;
  logic [BYTES-1:0] wStrb_q, wStrb_d;
  logic             bValid_q, bValid_d;
  logic [1:0]       bResp_q, bResp_d;
  logic [NUM_REGS-1:0] wrPulse_q, wrEn;
  logic [DW-1:0]    regs_q [NUM_REGS];
  logic [DW-1:0]    regs_d [NUM_REGS];
  logic             rValid_q, rValid_d;
  logic [DW-1:0]    rData_q, rData_d;
  logic [1:0]       rResp_q, rResp_d;

  logic             awFire, wFire, arFire, commit, rdHit;
  logic [IDX_W-1:0] cIdx, arIdx;
  logic [DW-1:0]    cData, rdMux;
  logic [BYTES-1:0] cStrb;
  logic             unusedBits;

  assign unusedBits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[ADDR_LSB-1:0],
                        s00_axi_araddr[ADDR_LSB-1:0], status_in};

  // READYs stay low until the first clock edge after reset is released.
  assign s00_axi_awready = readyEn_q && (awState_q == AW_IDLE) && !bValid_q;
  assign s00_axi_wready  = readyEn_q && (wState_q == W_IDLE) && !bValid_q;
  assign s00_axi_arready = readyEn_q && !rValid_q;

  assign awFire = s00_axi_awvalid && s00_axi_awready;
  assign wFire  = s00_axi_wvalid && s00_axi_wready;
  assign arFire = s00_axi_arvalid && s00_axi_arready;

  assign s00_axi_bvalid = bValid_q;
  assign s00_axi_bresp  = bResp_q;
  assign s00_axi_rvalid = rValid_q;
  assign s00_axi_rdata  = rData_q;
  assign s00_axi_rresp  = rResp_q;
  assign reg_wr_pulse   = wrPulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regOut
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

  // A write commits in the first cycle where address and data are both available,
  // taking each from its holding register or straight off the bus.
  always_comb begin
    cIdx   = (awState_q == AW_HELD) ? awIdx_q : s00_axi_awaddr[AW-1:ADDR_LSB];
    cData  = (wState_q == W_HELD) ? wData_q : s00_axi_wdata;
    cStrb  = (wState_q == W_HELD) ? wStrb_q : s00_axi_wstrb;
    commit = ((awState_q == AW_HELD) || awFire) && ((wState_q == W_HELD) || wFire);
    wrEn   = '0;
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && (cIdx == IDX_W'(i)) && !RO_MASK[i]) begin
        wrEn[i] = 1'b1;
        for (int b = 0; b < BYTES; b++) begin
          if (cStrb[b]) regs_d[i][8*b +: 8] = cData[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    awState_d = awState_q;
    wState_d  = wState_q;
    awIdx_d   = awIdx_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    bValid_d  = bValid_q;
    bResp_d   = bResp_q;
    if (commit) begin
      awState_d = AW_IDLE;
      wState_d  = W_IDLE;
      bValid_d  = 1'b1;
      bResp_d   = (|wrEn) ? RESP_OKAY : ERR_RESP;
    end else begin
      if (awFire) begin
        awState_d = AW_HELD;
        awIdx_d   = s00_axi_awaddr[AW-1:ADDR_LSB];
      end
      if (wFire) begin
        wState_d = W_HELD;
        wData_d  = s00_axi_wdata;
        wStrb_d  = s00_axi_wstrb;
      end
      if (bValid_q && s00_axi_bready) bValid_d = 1'b0;
    end
  end

  // Reads see regs_q, so a same-cycle write to the same register is not yet visible.
  always_comb begin
    arIdx = s00_axi_araddr[AW-1:ADDR_LSB];
    rdMux = '0;
    rdHit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (arIdx == IDX_W'(i)) begin
        rdHit = 1'b1;
        rdMux = RO_MASK[i] ? status_in[i*DW +: DW] : regs_q[i];
      end
    end
    rValid_d = rValid_q;
    rData_d  = rData_q;
    rResp_d  = rResp_q;
    if (arFire) begin
      rValid_d = 1'b1;
      rData_d  = rdMux;
      rResp_d  = rdHit ? RESP_OKAY : ERR_RESP;
    end else if (rValid_q && s00_axi_rready) begin
      rValid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      readyEn_q <= 1'b0;
      awState_q <= AW_IDLE;
      wState_q  <= W_IDLE;
      awIdx_q   <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
      wrPulse_q <= '0;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      readyEn_q <= 1'b1;
      awState_q <= awState_d;
      wState_q  <= wState_d;
      awIdx_q   <= awIdx_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      bValid_q  <= bValid_d;
      bResp_q   <= bResp_d;
      wrPulse_q <= wrEn;
      rValid_q  <= rValid_d;
      rData_q   <= rData_d;
      rResp_q   <= rResp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_axil_regbank_v2.sv
// Directed self-checking bench for axil_regbank_v2 (8 regs, 6-bit address, register 7 read-only).
module tb_axil_regbank_v2;

  localparam logic [31:0] RV = 32'h0000_5A5A;
`ifdef AXIL_REGBANK_ERR_RESP_EN
  localparam logic [1:0] ILLEGAL_RESP = 2'b10;
`else
  localparam logic [1:0] ILLEGAL_RESP = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   awaddr, araddr;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [255:0] regOut, statusIn;
  logic [7:0]   wrPulse;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  axil_regbank_v2 #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_REGS(8),
    .RO_MASK(8'h80), .RESET_VAL(RV)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg_out(regOut), .reg_wr_pulse(wrPulse), .status_in(statusIn)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One write; AW starts at cycle awStart and W at wStart (relative), B held off for bHold extra cycles.
  task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int awStart, input int wStart, input int bHold,
                               output int bLat, output logic [1:0] resp, output logic [7:0] pulse);
    bit awDone, wDone, awHs, wHs;
    int cyc;
    awDone = 0; wDone = 0; cyc = 0; bLat = 0; resp = 2'b11; pulse = '0;
    while (!(awDone && wDone) && cyc < 50) begin
      if (!awDone && cyc >= awStart) begin awvalid = 1'b1; awaddr = addr; end
      if (!wDone && cyc >= wStart) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      awHs = awvalid && awready;
      wHs  = wvalid && wready;
      @(negedge clk);
      if (awHs) begin awDone = 1; awvalid = 1'b0; end
      if (wHs) begin wDone = 1; wvalid = 1'b0; end
      cyc++;
    end
    if (!(awDone && wDone)) begin
      checkOutput("writeHandshakeTimeout", 1, 0);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    bLat = 1;
    while (!bvalid && bLat < 20) begin @(negedge clk); bLat++; end
    if (!bvalid) begin
      checkOutput("bvalidTimeout", 1, 0);
      return;
    end
    resp  = bresp;
    pulse = wrPulse;
    @(negedge clk);
    checkOutput("pulseOnce", wrPulse, 8'h00);
    checkOutput("bvalidHeld", bvalid, 1'b1);
    for (int k = 0; k < bHold; k++) begin
      @(negedge clk);
      checkOutput("bHoldValid", bvalid, 1'b1);
      checkOutput("bHoldResp", bresp, resp);
      checkOutput("bHoldAwready", awready, 1'b0);
      checkOutput("bHoldWready", wready, 1'b0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checkOutput("bvalidClear", bvalid, 1'b0);
    checkOutput("awreadyAfterB", awready, 1'b1);
  endtask

  task automatic readReg(input logic [5:0] addr, input int rHold, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic [255:0] saved;
    n = 0;
    arvalid = 1'b1; araddr = addr;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) checkOutput("arreadyTimeout", 1, 0);
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("rvalidLatency", rvalid, 1'b1);
    data = rdata; resp = rresp;
    saved = statusIn;
    for (int k = 0; k < rHold; k++) begin
      statusIn = ~saved;
      @(negedge clk);
      checkOutput("rdataStable", rdata, data);
    end
    statusIn = saved;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    checkOutput("rvalidClear", rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    logic [1:0] resp;
    logic [7:0] pulse;
    logic [31:0] data;

    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    statusIn = '0;
    statusIn[255:224] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    checkOutput("rstAwready", awready, 1'b0);
    checkOutput("rstWready", wready, 1'b0);
    checkOutput("rstArready", arready, 1'b0);
    checkOutput("rstBvalid", bvalid, 1'b0);
    checkOutput("rstRvalid", rvalid, 1'b0);
    checkOutput("rstRdata", rdata, 32'h0);
    checkOutput("rstPulse", wrPulse, 8'h00);
    checkOutput("rstRegOut", regOut, {8{RV}});
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterRst", {awready, wready, arready}, 3'b111);

    // Basic writes and readback
    for (int i = 0; i < 4; i++) begin
      applyStimulus(6'(4*i), 32'(i+1), 4'hF, 0, 0, 0, lat, resp, pulse);
      checkOutput("basicBLat", lat, 1);
      checkOutput("basicBresp", resp, 2'b00);
      checkOutput("basicPulse", pulse, 8'h01 << i);
    end
    checkOutput("basicRegOut", regOut[127:0], {32'h4, 32'h3, 32'h2, 32'h1});
    for (int i = 0; i < 4; i++) begin
      readReg(6'(4*i), 0, data, resp);
      checkOutput("basicRead", data, 32'(i+1));
      checkOutput("basicRresp", resp, 2'b00);
    end

    // Byte strobes
    applyStimulus(6'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0, lat, resp, pulse);
    applyStimulus(6'h00, 32'h11223344, 4'b0101, 0, 0, 0, lat, resp, pulse);
    readReg(6'h00, 0, data, resp);
    checkOutput("strobeRead", data, 32'hAA22CC44);

    // Decoupled AW/W ordering
    applyStimulus(6'h04, 32'hCAFE0001, 4'hF, 0, 3, 0, lat, resp, pulse);
    checkOutput("awFirstBLat", lat, 1);
    checkOutput("awFirstPulse", pulse, 8'h02);
    applyStimulus(6'h08, 32'h0BAD0002, 4'hF, 2, 0, 0, lat, resp, pulse);
    checkOutput("wFirstBLat", lat, 1);
    checkOutput("wFirstPulse", pulse, 8'h04);
    readReg(6'h04, 0, data, resp);
    checkOutput("awFirstRead", data, 32'hCAFE0001);
    readReg(6'h08, 0, data, resp);
    checkOutput("wFirstRead", data, 32'h0BAD0002);

    // B backpressure
    applyStimulus(6'h0C, 32'h12345678, 4'hF, 0, 0, 10, lat, resp, pulse);
    checkOutput("bpPulse", pulse, 8'h08);
    readReg(6'h0C, 0, data, resp);
    checkOutput("bpRead", data, 32'h12345678);

    // Read-only and out-of-range accesses
    applyStimulus(6'h1C, 32'h00000005, 4'hF, 0, 0, 0, lat, resp, pulse);
    checkOutput("roBresp", resp, ILLEGAL_RESP);
    checkOutput("roPulse", pulse, 8'h00);
    checkOutput("roRegOut", regOut[255:224], RV);
    readReg(6'h1C, 3, data, resp);
    checkOutput("roRead", data, 32'hDEADBEEF);
    checkOutput("roRresp", resp, 2'b00);
    readReg(6'h20, 0, data, resp);
    checkOutput("oorRead", data, 32'h0);
    checkOutput("oorRresp", resp, ILLEGAL_RESP);
    applyStimulus(6'h20, 32'h00000007, 4'hF, 0, 0, 0, lat, resp, pulse);
    checkOutput("oorBresp", resp, ILLEGAL_RESP);
    checkOutput("oorPulse", pulse, 8'h00);
    checkOutput("oorRegOut", regOut[127:0], {32'h12345678, 32'h0BAD0002, 32'hCAFE0001, 32'hAA22CC44});

    // Reset with AW held and W pending
    awvalid = 1'b1; awaddr = 6'h10;
    checkOutput("midAwready", awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h99999999; wstrb = 4'hF;
    #1 rst = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    checkOutput("midRstBvalid", bvalid, 1'b0);
    checkOutput("midRstRegOut", regOut, {8{RV}});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstAwready", awready, 1'b1);
    checkOutput("postRstBvalid", bvalid, 1'b0);
    checkOutput("postRstPulse", wrPulse, 8'h00);
    checkOutput("postRstRegOut", regOut, {8{RV}});
    readReg(6'h10, 0, data, resp);
    checkOutput("postRstRead", data, RV);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
